accumulator_drain_controller: RTL and testbench
===============================================

Name: accumulator_drain_controller

Overview:
Sequences the double-buffered accumulator bank array at tile boundaries. On a tile-done request it pulses `transfer` to swap front/back buffers. It then walks every (bank, entry) of the back buffer and streams each word out over a valid/ready interface to the output writer. It sits between the tile scheduler (tile_done/tile_ready) and the accumulator bank array's back-buffer read port.

Parameters:
BUFFER_WIDTH, 8, entries per bank; entry index width $clog2(BUFFER_WIDTH)
BANK_COUNT, 256, number of accumulator banks; bank index width $clog2(BANK_COUNT)
SMALLEST_ELEMENT_WIDTH, 4, read word is SMALLEST_ELEMENT_WIDTH*4 bits

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
tile_done  input  1  scheduler: front buffer holds a finished tile
bitwidth_in  input  2  precision of the finished tile
tile_ready  output  1  controller can accept tile_done (IDLE)
transfer  output  1  one-cycle buffer swap pulse to banks
bitwidth  output  2  latched precision driven to banks and downstream
back_buffer_bank_read  output  $clog2(BANK_COUNT)  bank select
back_buffer_bank_entry  output  $clog2(BUFFER_WIDTH)  entry select
back_buffer_data_read  input  SMALLEST_ELEMENT_WIDTH*4  read data, valid 1 cycle after address
out_data  output  SMALLEST_ELEMENT_WIDTH*4  drained word
out_bank  output  $clog2(BANK_COUNT)  bank of out_data
out_entry  output  $clog2(BUFFER_WIDTH)  entry of out_data
out_last  output  1  final word of tile
out_valid  output  1  out_* valid
out_ready  input  1  consumer accepts when out_valid&&out_ready
busy  output  1  state != IDLE
drain_done  output  1  one-cycle pulse when tile fully drained

Behaviour:
- Reset values:
  - state=IDLE; transfer=0; bitwidth=0; addresses=0; out_valid=0; out_last=0; drain_done=0; FIFO empty; in-flight cleared.
  - Reset in any state aborts the drain and discards FIFO contents. tile_ready=1 on the first cycle after reset deasserts.
- States: IDLE, XFER, DRAIN, FLUSH.
- IDLE:
  - tile_ready=1.
  - On tile_done: latch bitwidth_in into bitwidth and go to XFER.
- XFER:
  - transfer=1 for exactly this cycle; the first tile_done-accepting edge is followed by transfer high on the next cycle.
  - Counters (bank=0, entry=0) are cleared, then go to DRAIN.
- Read latency: the banks present back_buffer_data_read one cycle after the address. A 1-bit in-flight flag tracks the issued read, with its bank/entry/last tag.
- Output FIFO:
  - 2-entry FIFO carrying data, bank, entry and last.
  - Returning data is pushed unconditionally.
  - The FIFO head drives out_*; out_valid = FIFO non-empty.
- Issue rule in DRAIN: issue an address iff (fifo_count + inflight) < 2, or (fifo_count + inflight) == 2 and a pop occurs this cycle. This gives no overflow and 1 word/cycle sustained when out_ready is held high.
- Address order: entry increments first, 0..BUFFER_WIDTH-1. On entry wrap, bank increments, 0..BANK_COUNT-1.
- The last address is (BANK_COUNT-1, BUFFER_WIDTH-1). It is tagged last and, once issued, the state goes to FLUSH. Addresses hold their values when not issuing.
- FLUSH: when inflight=0 and the FIFO is empty after a pop, pulse drain_done for one cycle and return to IDLE.
- out_last=1 only on the word tagged last; exactly one per tile.
- Backpressure: with out_ready=0 the out_* signals are held stable, and at most 2 words (FIFO + in-flight) are outstanding.
- tile_done outside IDLE is ignored. The scheduler must hold it until tile_ready.
- bitwidth is stable from XFER through drain_done.
- transfer never asserts outside XFER. Total words per tile = BANK_COUNT*BUFFER_WIDTH.

Test Plan:
- Basic drain (BANK_COUNT=4, BUFFER_WIDTH=2):
  - Stimulus: reset, tile_done=1 for one cycle, out_ready=1, bank returns data={bank,entry}.
  - Required: transfer pulse 1 cycle after acceptance.
  - Required: 8 words in order (0,0),(0,1),(1,0)…(3,1), out_last on the 8th only, drain_done one cycle after the last pop, then tile_ready=1.
- Throughput: out_ready held 1.
  - Required: 8 consecutive out_valid&&out_ready cycles with no gaps after the first data returns.
- Backpressure: out_ready toggled 1,0,0,1 pattern.
  - Required: no word lost or duplicated; out_* stable while stalled; never more than 2 outstanding reads.
- Busy rejection: tile_done asserted during DRAIN.
  - Required: no second transfer pulse, tile_ready=0.
  - Required: held tile_done is accepted in IDLE after drain_done, with bitwidth_in=2'b10 latched.
- Reset mid-drain: reset asserted after 3 words.
  - Required: next cycle out_valid=0, busy=0, transfer=0, tile_ready=1.
  - Required: a new tile drains from (0,0).
- Bitwidth latch: bitwidth_in changes during DRAIN.
  - Required: bitwidth output unchanged until the next accepted tile_done.

Source files
------------

// File: rtl/accumulator_drain_controller.sv
// -----------------------------------------------------------------------------
// accumulator_drain_controller
//
// Sequences the double-buffered accumulator bank array at tile boundaries.
// A tile_done request from the scheduler is accepted in IDLE. The controller
// then pulses transfer for one cycle to swap the front and back buffers. It
// walks every (bank, entry) of the back buffer, entry-major within each bank,
// and streams each word to the output writer over a valid/ready interface.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   tile_done, bitwidth_in   scheduler request and precision of finished tile
//   tile_ready               controller idle, tile_done will be accepted
//   transfer                 one-cycle buffer swap pulse to the banks
//   bitwidth                 precision latched at tile acceptance
//   back_buffer_bank_read,
//   back_buffer_bank_entry   back-buffer read address
//   back_buffer_data_read    read data, valid one cycle after the address
//   out_data/bank/entry/last drained word with its address tag
//   out_valid, out_ready     output handshake
//   busy                     controller not idle
//   drain_done               one-cycle pulse once the tile is fully drained
// -----------------------------------------------------------------------------
module accumulator_drain_controller #(
    parameter int BUFFER_WIDTH           = 8,
    parameter int BANK_COUNT             = 256,
    parameter int SMALLEST_ELEMENT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                tile_done,
    input  logic [1:0]                          bitwidth_in,
    output logic                                tile_ready,
    output logic                                transfer,
    output logic [1:0]                          bitwidth,
    output logic [$clog2(BANK_COUNT)-1:0]       back_buffer_bank_read,
    output logic [$clog2(BUFFER_WIDTH)-1:0]     back_buffer_bank_entry,
    input  logic [SMALLEST_ELEMENT_WIDTH*4-1:0] back_buffer_data_read,
    output logic [SMALLEST_ELEMENT_WIDTH*4-1:0] out_data,
    output logic [$clog2(BANK_COUNT)-1:0]       out_bank,
    output logic [$clog2(BUFFER_WIDTH)-1:0]     out_entry,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                drain_done
);

    localparam int BANK_W  = $clog2(BANK_COUNT);
    localparam int ENTRY_W = $clog2(BUFFER_WIDTH);
    localparam int DATA_W  = SMALLEST_ELEMENT_WIDTH * 4;

    localparam logic [BANK_W-1:0]  LAST_BANK  = BANK_W'(BANK_COUNT - 1);
    localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(BUFFER_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 transfer_q, transfer_d;
    logic                 drain_done_q, drain_done_d;
    logic                 tile_ready_q, tile_ready_d;
    logic                 busy_q, busy_d;
    logic [1:0]           bitwidth_q, bitwidth_d;
    logic [BANK_W-1:0]    bank_q, bank_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;

    // Tag of the single read in flight; it travels with the returning data.
    logic                 inflight_q, inflight_d;
    logic [BANK_W-1:0]    if_bank_q, if_bank_d;
    logic [ENTRY_W-1:0]   if_entry_q, if_entry_d;
    logic                 if_last_q, if_last_d;

    // Two-entry output FIFO; head drives out_*.
    logic [DATA_W-1:0]    fifo_data_q  [2];
    logic [BANK_W-1:0]    fifo_bank_q  [2];
    logic [ENTRY_W-1:0]   fifo_entry_q [2];
    logic                 fifo_last_q  [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;

    logic                 push_s, pop_s, issue_s, last_addr_s;
    logic [1:0]           occ_s;

    // Handshake, occupancy and read-issue decisions for this cycle.
    always_comb begin
        push_s      = inflight_q;
        pop_s       = (count_q != 2'd0) && out_ready;
        occ_s       = count_q + {1'b0, inflight_q};
        // A pop in the same cycle frees the slot the new read will need.
        issue_s     = (state_q == DRAIN) &&
                      ((occ_s < 2'd2) || ((occ_s == 2'd2) && pop_s));
        last_addr_s = (bank_q == LAST_BANK) && (entry_q == LAST_ENTRY);
        count_d     = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // Next-state and next-output logic of the drain sequencer.
    always_comb begin
        state_d      = state_q;
        transfer_d   = 1'b0;
        drain_done_d = 1'b0;
        bitwidth_d   = bitwidth_q;
        bank_d       = bank_q;
        entry_d      = entry_q;
        inflight_d   = issue_s;
        if (issue_s) begin
            if_bank_d  = bank_q;
            if_entry_d = entry_q;
            if_last_d  = last_addr_s;
        end else begin
            if_bank_d  = if_bank_q;
            if_entry_d = if_entry_q;
            if_last_d  = if_last_q;
        end
        case (state_q)
            IDLE: begin
                if (tile_done) begin
                    bitwidth_d = bitwidth_in;
                    transfer_d = 1'b1;
                    state_d    = XFER;
                end else begin
                    state_d    = IDLE;
                end
            end
            XFER: begin
                bank_d  = '0;
                entry_d = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (issue_s && last_addr_s) begin
                    // Address holds on the final word; XFER clears it.
                    state_d = FLUSH;
                end else if (issue_s) begin
                    if (entry_q == LAST_ENTRY) begin
                        entry_d = '0;
                        bank_d  = bank_q + BANK_W'(1);
                    end else begin
                        entry_d = entry_q + ENTRY_W'(1);
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                // Nothing in flight and the last FIFO word leaves this cycle.
                if (!inflight_q && (count_q == 2'd1) && pop_s) begin
                    drain_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        tile_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // Sequencer state, counters, in-flight tag and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            transfer_q   <= 1'b0;
            drain_done_q <= 1'b0;
            tile_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            bitwidth_q   <= 2'b00;
            bank_q       <= '0;
            entry_q      <= '0;
            inflight_q   <= 1'b0;
            if_bank_q    <= '0;
            if_entry_q   <= '0;
            if_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            transfer_q   <= transfer_d;
            drain_done_q <= drain_done_d;
            tile_ready_q <= tile_ready_d;
            busy_q       <= busy_d;
            bitwidth_q   <= bitwidth_d;
            bank_q       <= bank_d;
            entry_q      <= entry_d;
            inflight_q   <= inflight_d;
            if_bank_q    <= if_bank_d;
            if_entry_q   <= if_entry_d;
            if_last_q    <= if_last_d;
        end
    end

    // FIFO pointers and occupancy; reset discards any queued words.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage: returning read data is captured with its tag.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_q[wr_ptr_q]  <= back_buffer_data_read;
            fifo_bank_q[wr_ptr_q]  <= if_bank_q;
            fifo_entry_q[wr_ptr_q] <= if_entry_q;
            fifo_last_q[wr_ptr_q]  <= if_last_q;
        end
    end

    assign tile_ready             = tile_ready_q;
    assign busy                   = busy_q;
    assign transfer               = transfer_q;
    assign drain_done             = drain_done_q;
    assign bitwidth               = bitwidth_q;
    assign back_buffer_bank_read  = bank_q;
    assign back_buffer_bank_entry = entry_q;
    assign out_valid              = (count_q != 2'd0);
    assign out_data               = fifo_data_q[rd_ptr_q];
    assign out_bank               = fifo_bank_q[rd_ptr_q];
    assign out_entry              = fifo_entry_q[rd_ptr_q];
    assign out_last               = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_accumulator_drain_controller.sv
// -----------------------------------------------------------------------------
// Bench for accumulator_drain_controller with 4 banks x 2 entries. The bank
// model returns {bank, entry} one cycle after the address, so the k-th word of
// a tile carries data == k, bank == k/2, entry == k%2. Inputs are driven and
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_accumulator_drain_controller;

    localparam int BC  = 4;
    localparam int BW  = 2;
    localparam int SEW = 4;
    localparam int DW  = SEW * 4;
    localparam int NW  = BC * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          tile_done;
    logic [1:0]    bitwidth_in;
    logic          tile_ready;
    logic          transfer;
    logic [1:0]    bitwidth;
    logic [1:0]    bb_bank;
    logic [0:0]    bb_entry;
    logic [DW-1:0] bb_data;
    logic [DW-1:0] out_data;
    logic [1:0]    out_bank;
    logic [0:0]    out_entry;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          drain_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    accumulator_drain_controller #(
        .BUFFER_WIDTH(BW), .BANK_COUNT(BC), .SMALLEST_ELEMENT_WIDTH(SEW)
    ) dut (
        .clk(clk), .reset(reset), .tile_done(tile_done), .bitwidth_in(bitwidth_in),
        .tile_ready(tile_ready), .transfer(transfer), .bitwidth(bitwidth),
        .back_buffer_bank_read(bb_bank), .back_buffer_bank_entry(bb_entry),
        .back_buffer_data_read(bb_data), .out_data(out_data), .out_bank(out_bank),
        .out_entry(out_entry), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .drain_done(drain_done)
    );

    // Bank array model: one-cycle read latency, data = {bank, entry}.
    always @(posedge clk) bb_data <= {13'd0, bb_bank, bb_entry};

    task automatic apply_reset;
        reset = 1'b1; tile_done = 1'b0; out_ready = 1'b0; bitwidth_in = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present tile_done for one accepting edge; returns in the XFER cycle.
    task automatic start_tile(input logic [1:0] bw);
        tile_done = 1'b1; bitwidth_in = bw;
        @(negedge clk);
        tile_done = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        total++; if (tile_ready !== 1'b1) begin bad++; $display("FAIL reset_tile_ready: got %b want 1", tile_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (transfer !== 1'b0) begin bad++; $display("FAIL reset_transfer: got %b want 0", transfer); end
        total++; if (out_valid !== 1'b0 || out_last !== 1'b0 || drain_done !== 1'b0) begin bad++; $display("FAIL reset_outs: valid=%b last=%b done=%b want 000", out_valid, out_last, drain_done); end
        total++; if (bitwidth !== 2'b00 || bb_bank !== 2'd0 || bb_entry !== 1'b0) begin bad++; $display("FAIL reset_regs: bw=%0d bank=%0d entry=%0d want 0 0 0", bitwidth, bb_bank, bb_entry); end
        @(negedge clk);
        total++; if (tile_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_hold: tile_ready=%b want 1", tile_ready); end
    endtask

    task automatic test_basic_drain;
        int  got  = 0;
        bit  done = 1'b0;
        out_ready = 1'b1;
        start_tile(2'b01);
        total++; if (transfer !== 1'b1) begin bad++; $display("FAIL basic_transfer: got %b want 1", transfer); end
        total++; if (tile_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_busy: ready=%b busy=%b want 0 1", tile_ready, busy); end
        total++; if (bitwidth !== 2'b01) begin bad++; $display("FAIL basic_bitwidth: got %0d want 1", bitwidth); end
        @(negedge clk);
        total++; if (transfer !== 1'b0) begin bad++; $display("FAIL basic_transfer_width: got %b want 0", transfer); end
        for (int c = 0; c < 40 && !done; c++) begin
            if (transfer !== 1'b0) begin total++; bad++; $display("FAIL basic_extra_transfer: got %b want 0", transfer); end
            if (got == NW) begin
                total++; if (drain_done !== 1'b1 || tile_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_done: done=%b ready=%b valid=%b want 1 1 0", drain_done, tile_ready, out_valid); end
                done = 1'b1;
            end else begin
                if (drain_done !== 1'b0) begin total++; bad++; $display("FAIL basic_early_done: after %0d words", got); end
                if (out_valid) begin
                    total++;
                    if (out_bank !== 2'(got / 2) || out_entry !== 1'(got % 2) || out_data !== DW'(got) || out_last !== (got == NW - 1)) begin
                        bad++; $display("FAIL basic_word%0d: bank=%0d entry=%0d data=%0d last=%b want %0d %0d %0d %b", got, out_bank, out_entry, out_data, out_last, got / 2, got % 2, got, got == NW - 1);
                    end
                    got++;
                end
                @(negedge clk);
            end
        end
        total++; if (!done) begin bad++; $display("FAIL basic_timeout: got %0d words want %0d", got, NW); end
    endtask

    task automatic test_throughput;
        int words = 0, first = -1, last_c = -1, gaps = 0;
        out_ready = 1'b1;
        start_tile(2'b00);
        for (int c = 0; c < 40 && words < NW; c++) begin
            if (out_valid) begin
                if (first < 0) first = c;
                last_c = c;
                words++;
            end else if (first >= 0) begin
                gaps++;
            end
            @(negedge clk);
        end
        total++; if (words !== NW) begin bad++; $display("FAIL tput_words: got %0d want %0d", words, NW); end
        total++; if (gaps !== 0 || (last_c - first) !== NW - 1) begin bad++; $display("FAIL tput_gaps: gaps=%0d span=%0d want 0 %0d", gaps, last_c - first, NW - 1); end
        total++; if (drain_done !== 1'b1) begin bad++; $display("FAIL tput_done: got %b want 1", drain_done); end
    endtask

    task automatic test_backpressure;
        logic [3:0]    pat = 4'b1001;
        logic          rdy;
        bit            stalled = 1'b0, done = 1'b0;
        logic [DW-1:0] s_data;
        logic [1:0]    s_bank;
        logic [0:0]    s_entry;
        logic          s_last;
        int            got = 0, idx;
        out_ready = 1'b0;
        start_tile(2'b11);
        for (int c = 0; c < 200 && !done; c++) begin
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== s_data || out_bank !== s_bank || out_entry !== s_entry || out_last !== s_last) begin
                    bad++; $display("FAIL bp_stall_hold: valid=%b data=%0d bank=%0d entry=%0d want 1 %0d %0d %0d", out_valid, out_data, out_bank, out_entry, s_data, s_bank, s_entry);
                end
            end
            if (busy && !transfer) begin
                idx = int'(bb_bank) * BW + int'(bb_entry);
                total++; if (idx - got > 2) begin bad++; $display("FAIL bp_outstanding: got %0d want <=2", idx - got); end
            end
            if (drain_done) begin
                total++; if (got !== NW) begin bad++; $display("FAIL bp_count: got %0d want %0d", got, NW); end
                done = 1'b1;
            end
            rdy = pat[c % 4];
            out_ready = rdy;
            if (out_valid && rdy) begin
                total++;
                if (out_data !== DW'(got) || out_bank !== 2'(got / 2) || out_entry !== 1'(got % 2) || out_last !== (got == NW - 1)) begin
                    bad++; $display("FAIL bp_word%0d: data=%0d bank=%0d entry=%0d last=%b want %0d", got, out_data, out_bank, out_entry, out_last, got);
                end
                got++;
            end
            stalled = out_valid && !rdy;
            s_data = out_data; s_bank = out_bank; s_entry = out_entry; s_last = out_last;
            @(negedge clk);
        end
        total++; if (!done) begin bad++; $display("FAIL bp_timeout: got %0d words want %0d", got, NW); end
        out_ready = 1'b1;
    endtask

    task automatic test_busy_reject;
        int  xfers = 0, got = 0;
        bit  done = 1'b0;
        out_ready = 1'b1;
        start_tile(2'b01);
        @(negedge clk);
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 3) begin tile_done = 1'b1; bitwidth_in = 2'b10; end
            if (transfer) xfers++;
            if (drain_done) begin
                done = 1'b1;
                total++; if (bitwidth !== 2'b01 || tile_ready !== 1'b1) begin bad++; $display("FAIL busy_done_state: bw=%0d ready=%b want 1 1", bitwidth, tile_ready); end
            end else begin
                if (c == 4) begin
                    total++; if (tile_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL busy_ready: ready=%b busy=%b want 0 1", tile_ready, busy); end
                end
                @(negedge clk);
            end
        end
        total++; if (!done || xfers !== 0) begin bad++; $display("FAIL busy_second_transfer: done=%b xfers=%0d want 1 0", done, xfers); end
        @(negedge clk);
        tile_done = 1'b0;
        total++; if (transfer !== 1'b1 || bitwidth !== 2'b10 || busy !== 1'b1) begin bad++; $display("FAIL busy_accept: xfer=%b bw=%0d busy=%b want 1 2 1", transfer, bitwidth, busy); end
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (drain_done) done = 1'b1;
            else begin
                if (out_valid) got++;
                @(negedge clk);
            end
        end
        total++; if (!done || got !== NW) begin bad++; $display("FAIL busy_second_tile: done=%b words=%0d want 1 %0d", done, got, NW); end
    endtask

    task automatic test_bitwidth_latch;
        bit done = 1'b0;
        int wrong = 0;
        logic [1:0] v;
        out_ready = 1'b1;
        start_tile(2'b11);
        total++; if (bitwidth !== 2'b11) begin bad++; $display("FAIL bw_latch: got %0d want 3", bitwidth); end
        for (int c = 0; c < 40 && !done; c++) begin
            v = 2'(c);
            bitwidth_in = v;
            if (bitwidth !== 2'b11) wrong++;
            if (drain_done) done = 1'b1;
            else @(negedge clk);
        end
        total++; if (!done || wrong !== 0) begin bad++; $display("FAIL bw_stable: done=%b changes=%0d want 1 0", done, wrong); end
        start_tile(2'b00);
        total++; if (bitwidth !== 2'b00 || transfer !== 1'b1) begin bad++; $display("FAIL bw_relatch: bw=%0d xfer=%b want 0 1", bitwidth, transfer); end
        apply_reset();
    endtask

    task automatic test_reset_mid_drain;
        int got = 0;
        bit done = 1'b0;
        out_ready = 1'b1;
        start_tile(2'b01);
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (out_valid) got++;
            if (got < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || transfer !== 1'b0 || tile_ready !== 1'b1) begin bad++; $display("FAIL rst_mid: valid=%b busy=%b xfer=%b ready=%b want 0 0 0 1", out_valid, busy, transfer, tile_ready); end
        reset = 1'b0;
        start_tile(2'b10);
        @(negedge clk);
        total++; if (bb_bank !== 2'd0 || bb_entry !== 1'b0) begin bad++; $display("FAIL rst_restart_addr: bank=%0d entry=%0d want 0 0", bb_bank, bb_entry); end
        got = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (drain_done) done = 1'b1;
            else begin
                if (out_valid) begin
                    total++;
                    if (out_data !== DW'(got) || out_bank !== 2'(got / 2) || out_entry !== 1'(got % 2)) begin
                        bad++; $display("FAIL rst_word%0d: data=%0d bank=%0d entry=%0d want %0d", got, out_data, out_bank, out_entry, got);
                    end
                    got++;
                end
                @(negedge clk);
            end
        end
        total++; if (!done || got !== NW) begin bad++; $display("FAIL rst_second_tile: done=%b words=%0d want 1 %0d", done, got, NW); end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_throughput();
        test_backpressure();
        test_busy_reject();
        test_bitwidth_latch();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
